// File: rtl/mips_haz_pkg.sv
// Shared types and constants for the MIPS pipeline interlock controller.
package mips_haz_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } haz_state_t;

  // Bits needed to hold a countdown starting at lat.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// ID/EX-side signal bundle between the pipeline datapath (master) and the interlock controller (slave).
interface mips_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import mips_haz_pkg::*;

  logic             start;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_wr;
  logic             id_load;
  logic             id_halt;
  logic             ex_taken;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output start, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_wr, id_load, id_halt, ex_taken,
    input  stall, bubble, flush, halted, stall_cnt
  );

  modport slave (
    input  start, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_rd, id_wr, id_load, id_halt, ex_taken,
    output stall, bubble, flush, halted, stall_cnt
  );

endinterface

// File: rtl/mips_scoreboard.sv
// Per-register countdown scoreboard for r1..r31; a register is busy while its count is nonzero.
module mips_scoreboard
  import mips_haz_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             load,
  input  logic [REG_W-1:0] load_rd,
  input  logic [CW-1:0]    load_val,
  input  logic             dec,
  input  logic [REG_W-1:0] rd_a,
  input  logic [REG_W-1:0] rd_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic             all_idle
);

  logic [NREG-1:0] busy_vec;

  // r0 is hardwired zero and can never be pending.
  assign busy_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;

      // A reload in the same cycle wins over the decrement.
      always_ff @(posedge clk1) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (load && (load_rd == REG_W'(gi))) begin
          cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - CW'(1);
        end
      end

      assign busy_vec[gi] = (cnt_reg != '0);
    end
  endgenerate

  assign busy_a   = busy_vec[rd_a];
  assign busy_b   = busy_vec[rd_b];
  assign all_idle = ~|busy_vec;

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline interlock controller: RAW stalls, branch flush, start/halt sequencing, stall counter.
// Build option: define HAZ_FWD_EN when ALU results are forwarded, so only loads create pending counts.
module mips_hazard_ctrl
  import mips_haz_pkg::*;
#(
  parameter int LAT      = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk1,
  input  logic               rst_n,
  mips_hazard_ctrl_if.slave  bus
);

  localparam int CW = cnt_width((LAT > LOAD_LAT) ? LAT : LOAD_LAT);

  haz_state_t       state_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic          busy_rs;
  logic          busy_rt;
  logic          all_idle;
  logic          hazard;
  logic          issue;
  logic          run_stall;
  logic          sb_load;
  logic [CW-1:0] load_val;

  mips_scoreboard #(.CW(CW)) u_sb (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .load     (sb_load),
    .load_rd  (bus.id_rd),
    .load_val (load_val),
    .dec      (1'b1),
    .rd_a     (bus.id_rs),
    .rd_b     (bus.id_rt),
    .busy_a   (busy_rs),
    .busy_b   (busy_rt),
    .all_idle (all_idle)
  );

  assign hazard = bus.id_valid & ((bus.id_use_rs & busy_rs) | (bus.id_use_rt & busy_rt));
  assign issue  = (state_reg == ST_RUN) & bus.id_valid & ~hazard & ~bus.ex_taken;

  // A taken branch discards the ID instruction, so it neither stalls nor writes the scoreboard.
  assign run_stall = (state_reg == ST_RUN) & hazard & ~bus.ex_taken;
  assign sb_load   = issue & bus.id_wr & (bus.id_rd != '0);

`ifdef HAZ_FWD_EN
  // Forwarded ALU writers load zero, cancelling any older count on the same register.
  assign load_val = bus.id_load ? CW'(LOAD_LAT) : '0;
`else
  logic unused_load;
  assign unused_load = bus.id_load;
  assign load_val    = CW'(LAT);
`endif

  assign bus.stall     = (state_reg == ST_RUN) ? run_stall : 1'b1;
  assign bus.bubble    = bus.ex_taken | run_stall;
  assign bus.flush     = bus.ex_taken;
  assign bus.halted    = (state_reg == ST_HALTED);
  assign bus.stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      stall_cnt_reg <= '0;
    end else begin
      if (run_stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        ST_IDLE:  if (bus.start) state_reg <= ST_RUN;
        ST_RUN:   if (issue && bus.id_halt) state_reg <= ST_DRAIN;
        ST_DRAIN: if (all_idle) state_reg <= ST_HALTED;
        default:  state_reg <= ST_HALTED;
      endcase
    end
  end

endmodule
